conv_layer_ifft: RTL

- Return path of the FFT convolution pipeline: takes frequency-domain 4x4 complex product tiles, one tile per two cachelines (real, then imaginary), and runs a 2D inverse FFT on each tile.
- Scales each result and packs the real part into one 512-bit cacheline per tile for write-back.
- Sits between the frequency-domain multiply/accumulate stage and the host output FIFO.

---
 rtl/conv_fft_pkg.sv | 49 ++++
 rtl/ifft4_2d.sv | 74 +++++++
 rtl/conv_layer_ifft.sv | 134 +++++++++++++
 3 files changed

// File: rtl/conv_fft_pkg.sv
// rtl/conv_fft_pkg.sv - shared types, constants and tile pack/unpack helpers for the FFT convolution path
package conv_fft_pkg;

  localparam int TILE_DIM       = 4;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = TILE_DIM * TILE_DIM;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
  // 2D 4x4 transform grows magnitudes by 16x; extra headroom keeps the sum exact
  localparam int IFFT_W         = WORD_W + 6;

  typedef struct packed {
    logic signed [WORD_W-1:0] r;
    logic signed [WORD_W-1:0] i;
  } complex_t;

  typedef struct packed {
    logic signed [IFFT_W-1:0] r;
    logic signed [IFFT_W-1:0] i;
  } cwide_t;

  typedef complex_t [WORDS_PER_LINE-1:0] ctile_t;
  typedef cwide_t   [WORDS_PER_LINE-1:0] wtile_t;
  typedef logic     [WORDS_PER_LINE-1:0][WORD_W-1:0] words_t;

  typedef enum logic {S_RE, S_IM} state_t;

  function automatic ctile_t unpack_tile(input logic [LINE_W-1:0] re,
                                         input logic [LINE_W-1:0] im);
    ctile_t t;
    t = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      t[w].r = re[w*WORD_W +: WORD_W];
      t[w].i = im[w*WORD_W +: WORD_W];
    end
    return t;
  endfunction

  function automatic logic [LINE_W-1:0] pack_tile(input words_t words);
    return words;
  endfunction

  function automatic cwide_t widen(input complex_t c);
    cwide_t y;
    y.r = IFFT_W'(c.r);
    y.i = IFFT_W'(c.i);
    return y;
  endfunction

endpackage

// File: rtl/ifft4_2d.sv
// rtl/ifft4_2d.sv - fixed-latency unscaled 4x4 complex 2D inverse DFT (row pass, column pass, delay line)
module ifft4_2d
  import conv_fft_pkg::*;
#(
  parameter int LATENCY = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   next,
  input  ctile_t tile_in,
  output logic   next_out,
  output wtile_t tile_out
);

  // Twiddles of a 4-point inverse DFT are powers of +j, so every product is a swap/negate.
  function automatic cwide_t idft4_pt(input cwide_t x0, input cwide_t x1,
                                      input cwide_t x2, input cwide_t x3,
                                      input int m);
    cwide_t y;
    y = '0;
    case (m)
      0: begin
        y.r = x0.r + x1.r + x2.r + x3.r;
        y.i = x0.i + x1.i + x2.i + x3.i;
      end
      1: begin
        y.r = x0.r - x1.i - x2.r + x3.i;
        y.i = x0.i + x1.r - x2.i - x3.r;
      end
      2: begin
        y.r = x0.r - x1.r + x2.r - x3.r;
        y.i = x0.i - x1.i + x2.i - x3.i;
      end
      default: begin
        y.r = x0.r + x1.i - x2.r - x3.i;
        y.i = x0.i - x1.r - x2.i + x3.r;
      end
    endcase
    return y;
  endfunction

  wtile_t             pipe [LATENCY];
  logic [LATENCY-1:0] vld;
  wtile_t             row_res;
  wtile_t             col_res;

  always_comb begin
    row_res = '0;
    col_res = '0;
    for (int k = 0; k < TILE_DIM; k++) begin
      for (int n = 0; n < TILE_DIM; n++) begin
        row_res[k*TILE_DIM+n] = idft4_pt(widen(tile_in[k*TILE_DIM+0]), widen(tile_in[k*TILE_DIM+1]),
                                         widen(tile_in[k*TILE_DIM+2]), widen(tile_in[k*TILE_DIM+3]), n);
        col_res[k*TILE_DIM+n] = idft4_pt(pipe[0][n], pipe[0][TILE_DIM+n],
                                         pipe[0][2*TILE_DIM+n], pipe[0][3*TILE_DIM+n], k);
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe[0] <= row_res;
    pipe[1] <= col_res;
    for (int s = 2; s < LATENCY; s++) pipe[s] <= pipe[s-1];
  end

  always_ff @(posedge clk) begin
    if (reset) vld <= '0;
    else       vld <= {vld[LATENCY-2:0], next};
  end

  assign next_out = vld[LATENCY-1];
  assign tile_out = pipe[LATENCY-1];

endmodule

// File: rtl/conv_layer_ifft.sv
// rtl/conv_layer_ifft.sv - IFFT return path: collect re/im lines, 2D IFFT, scale, FIFO out; CONV_IFFT_ROUND_EN rounds the scaling
module conv_layer_ifft
  import conv_fft_pkg::*;
#(
  parameter int IFFT_LATENCY = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int SCALE_SHIFT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ctx_length,
  input  logic              input_valid,
  output logic              input_ready,
  input  logic [LINE_W-1:0] cacheline_in,
  input  logic              output_fifo_full,
  output logic              output_valid,
  output logic [LINE_W-1:0] cacheline_out,
  output logic              done
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
`ifdef CONV_IFFT_ROUND_EN
  localparam logic signed [IFFT_W-1:0] ROUND_ADD = IFFT_W'(1 << (SCALE_SHIFT-1));
`endif

  state_t              state, state_nxt;
  logic [LINE_W-1:0]   real_buf;
  logic [31:0]         tiles_in, tiles_out;
  logic [AW:0]         credits, count;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LINE_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic                accept, reserve, ifft_next, ifft_next_out, push, pop;
  wtile_t              ifft_out;
  words_t              scaled;
  logic [LINE_W-1:0]   push_line;
  logic                unused_imag;

  assign accept = input_valid & input_ready;

  always_comb begin
    state_nxt   = state;
    input_ready = 1'b0;
    reserve     = 1'b0;
    ifft_next   = 1'b0;
    case (state)
      S_RE: begin
        // Credits cover in-flight tiles plus FIFO occupancy, so a push never overflows.
        input_ready = !reset && (tiles_in != ctx_length) && (credits < DEPTH_L);
        if (accept) begin
          reserve   = 1'b1;
          state_nxt = S_IM;
        end
      end
      default: begin
        input_ready = !reset;
        if (accept) begin
          ifft_next = 1'b1;
          state_nxt = S_RE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_RE;
    else       state <= state_nxt;
  end

  ifft4_2d #(.LATENCY(IFFT_LATENCY)) u_ifft (
    .clk      (clk),
    .reset    (reset),
    .next     (ifft_next),
    .tile_in  (unpack_tile(real_buf, cacheline_in)),
    .next_out (ifft_next_out),
    .tile_out (ifft_out)
  );

  always_comb begin
    scaled      = '0;
    unused_imag = 1'b0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
`ifdef CONV_IFFT_ROUND_EN
      scaled[w] = WORD_W'((ifft_out[w].r + ROUND_ADD) >>> SCALE_SHIFT);
`else
      scaled[w] = WORD_W'(ifft_out[w].r >>> SCALE_SHIFT);
`endif
      unused_imag = unused_imag ^ (^ifft_out[w].i);
    end
  end

  assign push_line = pack_tile(scaled);
  assign push      = ifft_next_out;
  assign pop       = (count != '0) && !output_fifo_full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_line;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      real_buf      <= '0;
      tiles_in      <= '0;
      tiles_out     <= '0;
      credits       <= '0;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      output_valid  <= 1'b0;
      cacheline_out <= '0;
      done          <= 1'b0;
    end else begin
      if (reserve)   real_buf  <= cacheline_in;
      if (ifft_next) tiles_in  <= tiles_in + 32'd1;
      if (pop)       tiles_out <= tiles_out + 32'd1;
      if (push)      wr_ptr    <= wr_ptr + AW'(1);
      if (pop)       rd_ptr    <= rd_ptr + AW'(1);
      case ({reserve, pop})
        2'b10:   credits <= credits + (AW+1)'(1);
        2'b01:   credits <= credits - (AW+1)'(1);
        default: credits <= credits;
      endcase
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      output_valid <= pop;
      if (pop) cacheline_out <= fifo_mem[rd_ptr];
      done <= done | (tiles_out == ctx_length);
    end
  end

endmodule
